viterbi_channel_err_inj: RTL and testbench
==========================================

// Module: viterbi_channel_err_inj
// PURPOSE
// - Channel model between the rate-1/2 convolutional encoder and the Viterbi decoder.
// - Consumes each 2-bit encoder symbol and forwards it to the decoder, optionally XOR-flipping bits.
// - Flip patterns: periodic, pseudo-random or burst. Used to measure decoder correction capability.
// PARAMETERS
// - PERIOD_W  16       width of cfg_period_i, cfg_burst_len_i and the period counter
// - CNT_W     32       width of the statistics counters
// - LFSR_SEED 16'hACE1 reset value of the 16-bit LFSR (must be nonzero)
// PORTS
// - clk              in   1        single clock, all logic on posedge
// - rst              in   1        synchronous, active-high reset
// - enc_sym_i        in   2        encoder symbol {g1,g0}
// - enc_valid_i      in   1        enc_sym_i valid this cycle
// - cfg_mode_i       in   2        0 PASS, 1 PERIODIC, 2 RANDOM, 3 BURST
// - cfg_period_i     in   PERIOD_W symbols between injections (0 = never inject)
// - cfg_thresh_i     in   8        RANDOM: inject when lfsr[7:0] < thresh
// - cfg_burst_len_i  in   PERIOD_W BURST: consecutive flipped symbols (0 treated as 1)
// - dec_sym_o        out  2        symbol to decoder = enc_sym_i ^ mask
// - dec_valid_o      out  1        dec_sym_o valid
// - err_mask_o       out  2        mask applied to the current dec_sym_o
// - err_cnt_o        out  CNT_W    flipped-bit count (stats feature only)
// - sym_cnt_o        out  CNT_W    forwarded-symbol count (stats feature only)
// BEHAVIOUR
// - Reset values: all outputs 0; FSM in ST_IDLE; period cnt 0; sel 2'b01; lfsr = LFSR_SEED.
// - Output timing: registered, latency exactly 1 clk.
//   - dec_valid_o(t+1) = enc_valid_i(t).
//   - dec_sym_o and err_mask_o update only on valid cycles and hold otherwise.
// - No backpressure. When enc_valid_i=0: nothing advances (lfsr, counters, FSM).
// - FSM states:
//   - ST_IDLE: entered when mode==0; mask 0.
//   - ST_ARMED: entered when mode!=0.
//   - ST_BURST: entered from ST_ARMED on a burst trigger.
// - Period counter cnt, ST_ARMED, modes 1 and 3:
//   - Advances per valid symbol.
//   - Trigger when cnt==cfg_period_i-1, then cnt<=0; otherwise cnt<=cnt+1.
//   - period==0: no trigger, cnt stays 0.
// - PERIODIC trigger: mask=sel, then sel toggles 01<->10.
// - RANDOM:
//   - lfsr is a Galois polynomial x^16+x^14+x^13+x^11+1; it shifts once per valid symbol.
//   - Decision uses the pre-shift value: flip when lfsr[7:0] < cfg_thresh_i.
//   - Flipped bit: lfsr[8] ? 2'b10 : 2'b01.
// - BURST:
//   - Trigger symbol gets mask 2'b01 and the FSM goes to ST_BURST with rem = max(len,1)-1.
//   - Each valid symbol in ST_BURST gets mask 2'b01 and decrements rem.
//   - Exit to ST_ARMED on the symbol where rem==0 was consumed.
//   - cnt is frozen during ST_BURST.
//   - len==1: single flip, no ST_BURST entry.
// - Mode change (cfg_mode_i differs from the registered mode on any cycle):
//   - Abort any burst; cnt<=0, sel<=01; FSM re-enters per new mode; lfsr untouched.
//   - New mode applies to the next valid symbol.
// - rst mid-burst: immediate return to reset values on the next clk; no residual flips.
// - Counters:
//   - err_cnt += popcount(mask) per valid symbol.
//   - sym_cnt += 1 per valid symbol.
//   - Both saturate at all-ones (no wrap).
// CONFIGURATION
// - Macro ERR_INJ_STATS_EN:
//   - Defined: err_cnt_o/sym_cnt_o counters built as above; reset by rst only.
//   - Undefined: no counter flops; err_cnt_o and sym_cnt_o tied to 0.
//   - Datapath identical in both cases.
// TESTING
// - T1 PASS: mode0, 64 random valid symbols -> dec_sym_o==enc_sym_i delayed 1 clk; err_mask_o==0 always.
// - T2 PERIODIC: mode1, period=4, enc_sym_i=00 each cycle
//   -> symbols 4,8,12,16 out as 01,10,01,10; all others 00.
//   -> [STATS] err_cnt_o=4, sym_cnt_o=16.
// - T3 BURST: mode3, period=8, len=3, sym=00 continuous
//   -> flips (01) on symbols 8,9,10 and 18,19,20 only; err_cnt_o=6 after 20.
// - T4 RANDOM:
//   -> thresh=0: 1000 symbols give err_cnt_o==0.
//   -> thresh=8'hFF: flip pattern matches a reference LFSR model from LFSR_SEED bit-exact.
// - T5 valid gaps: period=4, enc_valid_i toggling 1,0,1,0
//   -> flips on the 4th/8th valid symbol; dec_valid_o mirrors enc_valid_i delayed 1; outputs hold in gaps.
// - T6 reset mid-burst: assert rst during symbol 9 of T3
//   -> next clk all outputs 0, lfsr==LFSR_SEED.
//   -> after release, first flip on the 8th subsequent valid symbol.

Source files
------------

// File: rtl/viterbi_channel_err_inj.sv
// Channel model between the convolutional encoder and the Viterbi decoder: forwards symbols with
// periodic, pseudo-random or burst bit flips. Optional statistics counters under ERR_INJ_STATS_EN.
module viterbi_channel_err_inj #(
    parameter int unsigned PERIOD_W  = 16,
    parameter int unsigned CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          enc_sym_i,
    input  logic                enc_valid_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic [7:0]          cfg_thresh_i,
    input  logic [PERIOD_W-1:0] cfg_burst_len_i,
    output logic [1:0]          dec_sym_o,
    output logic                dec_valid_o,
    output logic [1:0]          err_mask_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic [CNT_W-1:0]    sym_cnt_o
);

    localparam logic [1:0]  MODE_PASS     = 2'd0;
    localparam logic [1:0]  MODE_PERIODIC = 2'd1;
    localparam logic [1:0]  MODE_RANDOM   = 2'd2;
    localparam logic [1:0]  MODE_BURST    = 2'd3;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] rem_q, rem_d;
    logic [1:0]          sel_q, sel_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [1:0]          mask_c;
    logic                mode_chg_c;
    logic                trig_c;

    // Period trigger shared by PERIODIC and BURST modes; period 0 never fires.
    always_comb begin
        trig_c = 1'b0;
        if (cfg_period_i != '0) begin
            trig_c = (cnt_q >= (cfg_period_i - PERIOD_W'(1)));
        end
    end

    // Next-state and flip mask; a mode change aborts everything except the LFSR.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        sel_d      = sel_q;
        lfsr_d     = lfsr_q;
        mask_c     = 2'b00;
        mode_chg_c = (cfg_mode_i != mode_q);

        if (mode_chg_c) begin
            state_d = (cfg_mode_i == MODE_PASS) ? ST_IDLE : ST_ARMED;
            cnt_d   = '0;
            rem_d   = '0;
            sel_d   = 2'b01;
        end else if (enc_valid_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mode_q != MODE_PASS) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    unique case (mode_q)
                        MODE_PERIODIC: begin
                            if (cfg_period_i != '0) begin
                                if (trig_c) begin
                                    mask_c = sel_q;
                                    sel_d  = {sel_q[0], sel_q[1]};
                                    cnt_d  = '0;
                                end else begin
                                    cnt_d = cnt_q + PERIOD_W'(1);
                                end
                            end
                        end
                        MODE_RANDOM: begin
                            if (lfsr_q[7:0] < cfg_thresh_i) begin
                                mask_c = lfsr_q[8] ? 2'b10 : 2'b01;
                            end
                            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
                        end
                        MODE_BURST: begin
                            if (cfg_period_i != '0) begin
                                if (trig_c) begin
                                    mask_c = 2'b01;
                                    cnt_d  = '0;
                                    if (cfg_burst_len_i > PERIOD_W'(1)) begin
                                        state_d = ST_BURST;
                                        rem_d   = cfg_burst_len_i - PERIOD_W'(1);
                                    end
                                end else begin
                                    cnt_d = cnt_q + PERIOD_W'(1);
                                end
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_BURST: begin
                    // rem counts burst symbols still owed after the trigger symbol.
                    mask_c = 2'b01;
                    rem_d  = rem_q - PERIOD_W'(1);
                    if (rem_q <= PERIOD_W'(1)) begin
                        state_d = ST_ARMED;
                        rem_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_PASS;
            cnt_q       <= '0;
            rem_q       <= '0;
            sel_q       <= 2'b01;
            lfsr_q      <= LFSR_SEED;
            dec_sym_o   <= 2'b00;
            dec_valid_o <= 1'b0;
            err_mask_o  <= 2'b00;
        end else begin
            state_q     <= state_d;
            mode_q      <= cfg_mode_i;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            lfsr_q      <= lfsr_d;
            dec_valid_o <= enc_valid_i;
            if (enc_valid_i) begin
                dec_sym_o  <= enc_sym_i ^ mask_c;
                err_mask_o <= mask_c;
            end
        end
    end

`ifdef ERR_INJ_STATS_EN
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [SUM_W-1:0] err_sum_c;
    logic [SUM_W-1:0] sym_sum_c;

    // Saturating statistics: overflow into the extra sum bit pins the counter at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        sym_cnt_d = sym_cnt_q;
        err_sum_c = {1'b0, err_cnt_q} + SUM_W'(mask_c[0]) + SUM_W'(mask_c[1]);
        sym_sum_c = {1'b0, sym_cnt_q} + SUM_W'(1);
        if (enc_valid_i) begin
            err_cnt_d = err_sum_c[CNT_W] ? '1 : err_sum_c[CNT_W-1:0];
            sym_cnt_d = sym_sum_c[CNT_W] ? '1 : sym_sum_c[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            sym_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign sym_cnt_o = sym_cnt_q;
`else
    assign err_cnt_o = '0;
    assign sym_cnt_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_channel_err_inj.sv
// Directed bench for viterbi_channel_err_inj: pass-through, periodic, burst, random, valid gaps, reset mid-burst.
module tb_viterbi_channel_err_inj;

    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned CNT_W    = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          enc_sym_i;
    logic                enc_valid_i;
    logic [1:0]          cfg_mode_i;
    logic [PERIOD_W-1:0] cfg_period_i;
    logic [7:0]          cfg_thresh_i;
    logic [PERIOD_W-1:0] cfg_burst_len_i;
    logic [1:0]          dec_sym_o;
    logic                dec_valid_o;
    logic [1:0]          err_mask_o;
    logic [CNT_W-1:0]    err_cnt_o;
    logic [CNT_W-1:0]    sym_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    viterbi_channel_err_inj #(
        .PERIOD_W (PERIOD_W),
        .CNT_W    (CNT_W),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enc_sym_i      (enc_sym_i),
        .enc_valid_i    (enc_valid_i),
        .cfg_mode_i     (cfg_mode_i),
        .cfg_period_i   (cfg_period_i),
        .cfg_thresh_i   (cfg_thresh_i),
        .cfg_burst_len_i(cfg_burst_len_i),
        .dec_sym_o      (dec_sym_o),
        .dec_valid_o    (dec_valid_o),
        .err_mask_o     (err_mask_o),
        .err_cnt_o      (err_cnt_o),
        .sym_cnt_o      (sym_cnt_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, return 1 time unit after the following rising edge.
    task automatic drive(input logic v, input logic [1:0] s);
        @(negedge clk);
        enc_valid_i = v;
        enc_sym_i   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst         = 1'b1;
        enc_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) drive(1'b0, 2'b00);
    endtask

    task automatic test_reset();
        cfg_mode_i = 2'd0; cfg_period_i = '0; cfg_thresh_i = 8'd0; cfg_burst_len_i = '0;
        enc_sym_i = 2'b11; enc_valid_i = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dec_sym_o !== 2'b00 || dec_valid_o !== 1'b0 || err_mask_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: got sym=%b valid=%b mask=%b, want 00/0/00", dec_sym_o, dec_valid_o, err_mask_o);
        end
        n_checks++;
        if (err_cnt_o !== '0 || sym_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got err=%0d sym=%0d, want 0/0", err_cnt_o, sym_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        enc_valid_i = 1'b0;
        repeat (2) drive(1'b0, 2'b00);
    endtask

    task automatic test_pass();
        logic [1:0] s;
        cfg_mode_i = 2'd0;
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            s = 2'($urandom_range(0, 3));
            drive(1'b1, s);
            n_checks++;
            if (dec_valid_o !== 1'b1 || dec_sym_o !== s || err_mask_o !== 2'b00) begin
                n_fail++;
                $display("FAIL pass_sym%0d: got v=%b sym=%b mask=%b, want 1/%b/00", i, dec_valid_o, dec_sym_o, err_mask_o, s);
            end
        end
        drive(1'b0, 2'b00);
`ifdef ERR_INJ_STATS_EN
        n_checks++;
        if (err_cnt_o !== 32'd0 || sym_cnt_o !== 32'd64) begin
            n_fail++;
            $display("FAIL pass_stats: got err=%0d sym=%0d, want 0/64", err_cnt_o, sym_cnt_o);
        end
`endif
    endtask

    task automatic test_periodic();
        logic [1:0] exp_m;
        cfg_mode_i = 2'd1; cfg_period_i = 16'd4;
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 2'b00);
            exp_m = 2'b00;
            if (k == 4 || k == 12) exp_m = 2'b01;
            if (k == 8 || k == 16) exp_m = 2'b10;
            n_checks++;
            if (dec_sym_o !== exp_m || err_mask_o !== exp_m) begin
                n_fail++;
                $display("FAIL periodic_sym%0d: got sym=%b mask=%b, want %b", k, dec_sym_o, err_mask_o, exp_m);
            end
        end
        drive(1'b0, 2'b00);
        n_checks++;
`ifdef ERR_INJ_STATS_EN
        if (err_cnt_o !== 32'd4 || sym_cnt_o !== 32'd16) begin
            n_fail++;
            $display("FAIL periodic_stats: got err=%0d sym=%0d, want 4/16", err_cnt_o, sym_cnt_o);
        end
`else
        if (err_cnt_o !== 32'd0 || sym_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_tied_off: got err=%0d sym=%0d, want 0/0", err_cnt_o, sym_cnt_o);
        end
`endif
    endtask

    task automatic test_burst();
        logic [1:0] exp_m;
        cfg_mode_i = 2'd3; cfg_period_i = 16'd8; cfg_burst_len_i = 16'd3;
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 2'b00);
            exp_m = ((k >= 8 && k <= 10) || (k >= 18 && k <= 20)) ? 2'b01 : 2'b00;
            n_checks++;
            if (dec_sym_o !== exp_m || err_mask_o !== exp_m) begin
                n_fail++;
                $display("FAIL burst_sym%0d: got sym=%b mask=%b, want %b", k, dec_sym_o, err_mask_o, exp_m);
            end
        end
        drive(1'b0, 2'b00);
`ifdef ERR_INJ_STATS_EN
        n_checks++;
        if (err_cnt_o !== 32'd6 || sym_cnt_o !== 32'd20) begin
            n_fail++;
            $display("FAIL burst_stats: got err=%0d sym=%0d, want 6/20", err_cnt_o, sym_cnt_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] lfsr;
        logic [1:0]  s, exp_m;
        int          flips;
        cfg_mode_i = 2'd2; cfg_thresh_i = 8'd0;
        apply_reset();
        flips = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 2'b00);
            if (err_mask_o != 2'b00) flips++;
        end
        n_checks++;
        if (flips !== 0) begin
            n_fail++;
            $display("FAIL random_thresh0: got %0d flipped symbols, want 0", flips);
        end
        cfg_thresh_i = 8'hFF;
        apply_reset();
        lfsr = 16'hACE1;
        for (int i = 0; i < 200; i++) begin
            s = 2'($urandom_range(0, 3));
            drive(1'b1, s);
            exp_m = 2'b00;
            if (lfsr[7:0] < 8'hFF) exp_m = lfsr[8] ? 2'b10 : 2'b01;
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            n_checks++;
            if (err_mask_o !== exp_m || dec_sym_o !== (s ^ exp_m)) begin
                n_fail++;
                $display("FAIL random_sym%0d: got sym=%b mask=%b, want sym=%b mask=%b", i, dec_sym_o, err_mask_o, s ^ exp_m, exp_m);
            end
        end
        drive(1'b0, 2'b00);
    endtask

    task automatic test_valid_gaps();
        logic [1:0] s, exp_m, last_sym, last_m;
        int         n;
        cfg_mode_i = 2'd1; cfg_period_i = 16'd4;
        apply_reset();
        n = 0; last_sym = 2'b00; last_m = 2'b00;
        for (int c = 0; c < 20; c++) begin
            s = 2'(c + 1);
            if (c % 2 == 0) begin
                drive(1'b1, s);
                n++;
                exp_m = (n == 4) ? 2'b01 : ((n == 8) ? 2'b10 : 2'b00);
                last_sym = s ^ exp_m;
                last_m   = exp_m;
                n_checks++;
                if (dec_valid_o !== 1'b1 || dec_sym_o !== last_sym || err_mask_o !== last_m) begin
                    n_fail++;
                    $display("FAIL gaps_valid%0d: got v=%b sym=%b mask=%b, want 1/%b/%b", n, dec_valid_o, dec_sym_o, err_mask_o, last_sym, last_m);
                end
            end else begin
                drive(1'b0, s);
                n_checks++;
                if (dec_valid_o !== 1'b0 || dec_sym_o !== last_sym || err_mask_o !== last_m) begin
                    n_fail++;
                    $display("FAIL gaps_hold_c%0d: got v=%b sym=%b mask=%b, want 0/%b/%b", c, dec_valid_o, dec_sym_o, err_mask_o, last_sym, last_m);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] exp_m;
        cfg_mode_i = 2'd3; cfg_period_i = 16'd8; cfg_burst_len_i = 16'd3;
        apply_reset();
        for (int k = 1; k <= 8; k++) drive(1'b1, 2'b00);
        n_checks++;
        if (err_mask_o !== 2'b01) begin
            n_fail++;
            $display("FAIL midburst_trigger: got mask=%b, want 01", err_mask_o);
        end
        @(negedge clk);
        rst = 1'b1; enc_valid_i = 1'b1; enc_sym_i = 2'b00;
        @(posedge clk);
        #1;
        n_checks++;
        if (dec_sym_o !== 2'b00 || dec_valid_o !== 1'b0 || err_mask_o !== 2'b00 || err_cnt_o !== '0 || sym_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL midburst_reset: got sym=%b v=%b mask=%b err=%0d cnt=%0d, want all 0", dec_sym_o, dec_valid_o, err_mask_o, err_cnt_o, sym_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0; enc_valid_i = 1'b0;
        repeat (2) drive(1'b0, 2'b00);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 2'b00);
            exp_m = (k == 8) ? 2'b01 : 2'b00;
            n_checks++;
            if (err_mask_o !== exp_m || dec_sym_o !== exp_m) begin
                n_fail++;
                $display("FAIL postreset_sym%0d: got sym=%b mask=%b, want %b", k, dec_sym_o, err_mask_o, exp_m);
            end
        end
        drive(1'b0, 2'b00);
    endtask

    initial begin
        rst = 1'b0;
        enc_valid_i = 1'b0; enc_sym_i = 2'b00;
        cfg_mode_i = 2'd0; cfg_period_i = '0; cfg_thresh_i = 8'd0; cfg_burst_len_i = '0;
        test_reset();
        test_pass();
        test_periodic();
        test_burst();
        test_random();
        test_valid_gaps();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
